// File: rtl/conv2d_pkg.sv
// Shared definitions for the 2D convolution blocks: controller states and the
// padding/width rules common to the sequential and combinational variants.
package conv2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CALC,
    OUT
  } state_e;

  // Zero-padding needed on each side for a "same"-size result.
  function automatic int calc_zp(input int n);
    return (n - 1) / 2;
  endfunction

  // Result width: full product plus headroom for summing N*N products.
  function automatic int calc_ow(input int w1, input int w2, input int n);
    return w1 + w2 + n * n - 1;
  endfunction

endpackage

// File: rtl/conv2d_mac.sv
// Single unsigned multiply-accumulate with a registered accumulator; the first
// tap of each output loads the accumulator instead of adding to it.
module conv2d_mac
  import conv2d_pkg::*;
#(
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 3,
  parameter int N      = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   en_i,
  input  logic                                   first_i,
  input  logic [WIDTH1-1:0]                      pix_i,
  input  logic [WIDTH2-1:0]                      coef_i,
  output logic [calc_ow(WIDTH1, WIDTH2, N)-1:0]  acc_nxt_o
);

  localparam int PW = WIDTH1 + WIDTH2;
  localparam int OW = calc_ow(WIDTH1, WIDTH2, N);

  logic [PW-1:0] prod;
  logic [OW-1:0] acc_q;
  logic [OW-1:0] acc_d;

  always_comb begin
    prod  = PW'(pix_i) * PW'(coef_i);
    acc_d = first_i ? OW'(prod) : acc_q + OW'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  // The controller captures the completed sum on the same edge as the last tap.
  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/conv2d_seq_ctrl.sv
// Serial-in, serial-out "same"-size 2D convolution: buffers one frame and one
// kernel, then walks every output pixel through a single shared MAC.
module conv2d_seq_ctrl
  import conv2d_pkg::*;
#(
  parameter int M      = 4,
  parameter int N      = 3,
  parameter int WIDTH1 = 8,
  parameter int WIDTH2 = 3
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic [WIDTH1-1:0]                      in_img,
  input  logic [WIDTH2-1:0]                      in_ker,
  output logic                                   out_valid,
  output logic [calc_ow(WIDTH1, WIDTH2, N)-1:0]  out_data,
  output logic                                   busy
);

  localparam int ZP   = calc_zp(N);
  localparam int OW   = calc_ow(WIDTH1, WIDTH2, N);
  localparam int NPIX = M * M;
  localparam int NTAP = N * N;
  localparam int BW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int TW   = (NTAP > 1) ? $clog2(NTAP) : 1;
  localparam int RW   = (M > 1) ? $clog2(M) : 1;
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int AW   = $clog2(M + N) + 1;

  localparam logic [BW-1:0] B_LAST = BW'(NPIX - 1);
  localparam logic [TW-1:0] T_LAST = TW'(NTAP - 1);
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [AW-1:0] ZP_A   = AW'(ZP);
  localparam logic [AW-1:0] HI_A   = AW'(M + ZP);
  localparam logic [BW-1:0] M_B    = BW'(M);
  localparam logic [BW:0]   NTAP_B = (BW + 1)'(NTAP);

  state_e            state_q;
  logic [BW-1:0]     beat_q;
  logic [RW-1:0]     i_q, j_q;
  logic [KW-1:0]     k_q, h_q;
  logic [TW-1:0]     t_q;
  logic [WIDTH1-1:0] img_q [NPIX];
  logic [WIDTH2-1:0] ker_q [NTAP];
  logic              out_valid_q;
  logic [OW-1:0]     out_data_q;
  logic              busy_q;

  logic [AW-1:0]     r_sum, c_sum, r_img, c_img;
  logic              in_rng;
  logic [BW-1:0]     rd_idx;
  logic [WIDTH1-1:0] pix;
  logic [WIDTH2-1:0] coef;
  logic              mac_en, mac_first;
  logic [OW-1:0]     acc_nxt;

  // Tap (k,h) of output (i,j) reads image (i+k-ZP, j+h-ZP); sums are kept
  // offset by ZP so the padding test needs no signed arithmetic.
  always_comb begin
    r_sum     = AW'(i_q) + AW'(k_q);
    c_sum     = AW'(j_q) + AW'(h_q);
    r_img     = r_sum - ZP_A;
    c_img     = c_sum - ZP_A;
    in_rng    = (r_sum >= ZP_A) && (r_sum < HI_A) && (c_sum >= ZP_A) && (c_sum < HI_A);
    rd_idx    = BW'(r_img) * M_B + BW'(c_img);
    pix       = in_rng ? img_q[rd_idx] : '0;
    coef      = ker_q[t_q];
    mac_en    = (state_q == CALC);
    mac_first = (t_q == '0);
  end

  conv2d_mac #(
    .WIDTH1 (WIDTH1),
    .WIDTH2 (WIDTH2),
    .N      (N)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (mac_en),
    .first_i   (mac_first),
    .pix_i     (pix),
    .coef_i    (coef),
    .acc_nxt_o (acc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      h_q         <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      for (int p = 0; p < NPIX; p++) img_q[p] <= '0;
      for (int p = 0; p < NTAP; p++) ker_q[p] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            img_q[0] <= in_img;
            ker_q[0] <= in_ker;
            beat_q   <= BW'(1);
            busy_q   <= 1'b1;
            state_q  <= LOAD;
          end
        end
        LOAD: begin
          // A gap in in_valid simply holds the beat counter.
          if (in_valid) begin
            img_q[beat_q] <= in_img;
            if ({1'b0, beat_q} < NTAP_B) ker_q[beat_q[TW-1:0]] <= in_ker;
            if (beat_q == B_LAST) begin
              beat_q  <= '0;
              state_q <= CALC;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        CALC: begin
          if (h_q == K_LAST) begin
            h_q <= '0;
            k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
          end else begin
            h_q <= h_q + 1'b1;
          end
          if (t_q == T_LAST) begin
            t_q         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= acc_nxt;
            state_q     <= OUT;
          end else begin
            t_q <= t_q + 1'b1;
          end
        end
        OUT: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          if (j_q == R_LAST) begin
            j_q <= '0;
            if (i_q == R_LAST) begin
              i_q     <= '0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              i_q     <= i_q + 1'b1;
              state_q <= CALC;
            end
          end else begin
            j_q     <= j_q + 1'b1;
            state_q <= CALC;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_conv2d_seq_ctrl.sv
// Directed bench for conv2d_seq_ctrl: table of frame/kernel vectors streamed
// back-to-back, plus a mid-computation reset sequence.
module tb_conv2d_seq_ctrl;

  localparam int M  = 4;
  localparam int N  = 3;
  localparam int W1 = 8;
  localparam int W2 = 3;
  localparam int OW = W1 + W2 + N * N - 1;
  localparam int NP = M * M;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W1-1:0] in_img = '0;
  logic [W2-1:0] in_ker = '0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          busy;

  conv2d_seq_ctrl #(.M(M), .N(N), .WIDTH1(W1), .WIDTH2(W2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_img    (in_img),
    .in_ker    (in_ker),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // pixel p = (p*mul + add) mod 256; kk: 0 ones, 1 identity, 2 sevens, 3 pattern.
  // ec/ee/ei: hand values at corner/edge/interior (-1 = not applicable).
  typedef struct {
    string name;
    int    mul;
    int    add;
    int    kk;
    bit    gaps;
    int    ec;
    int    ee;
    int    ei;
    bit    ident;
  } vec_t;

  vec_t vecs[5];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int px(input int vi, input int p);
    return (p * vecs[vi].mul + vecs[vi].add) % 256;
  endfunction

  function automatic int kr(input int vi, input int t);
    case (vecs[vi].kk)
      0:       return 1;
      1:       return (t == (N * N - 1) / 2) ? 1 : 0;
      2:       return 7;
      default: return (t * 3 + 1) % 8;
    endcase
  endfunction

  function automatic int model(input int vi, input int i, input int j);
    int acc = 0;
    for (int k = 0; k < N; k++)
      for (int h = 0; h < N; h++) begin
        int r = i + k - (N - 1) / 2;
        int c = j + h - (N - 1) / 2;
        if (r >= 0 && r < M && c >= 0 && c < M) acc += px(vi, r * M + c) * kr(vi, k * N + h);
      end
    return acc;
  endfunction

  function automatic int hand(input int vi, input int i, input int j);
    int edges = ((i == 0 || i == M - 1) ? 1 : 0) + ((j == 0 || j == M - 1) ? 1 : 0);
    if (edges == 2) return vecs[vi].ec;
    if (edges == 1) return vecs[vi].ee;
    return vecs[vi].ei;
  endfunction

  // Starts at a negedge; returns right after the edge that samples the last beat.
  task automatic send_frame(input int vi);
    for (int p = 0; p < NP; p++) begin
      if (p > 0) @(negedge clk);
      if (p == 1) chk("busy_rise", 32'(busy), 1);
      if (vecs[vi].gaps && (p % 3 == 1)) begin
        in_valid = 1'b0;
        in_img   = W1'($urandom);
        in_ker   = W2'($urandom);
        @(posedge clk);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_img   = W1'(px(vi, p));
      in_ker   = (p < N * N) ? W2'(kr(vi, p)) : W2'($urandom);
      @(posedge clk);
    end
  endtask

  // Negedge n counts cycles after the last beat; output k is due at n = 10*(k+1).
  task automatic collect(input int vi, input bit hold, input int stop_n);
    int cnt     = 0;
    bit done    = 0;
    bit zero_ok = 1;
    bit busy_ok = 1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (stop_n > 0 && n == stop_n) return;
      if (cnt == NP) begin
        chk("busy_fall", 32'(busy), 0);
        chk("valid_after_frame", 32'(out_valid), 0);
        in_valid = 1'b0;
        done = 1;
        break;
      end
      if (!busy) busy_ok = 0;
      if (out_valid) begin
        chk({vecs[vi].name, "_timing"}, 32'(n), 32'(10 * (cnt + 1)));
        chk({vecs[vi].name, "_model"}, 32'(out_data), 32'(model(vi, cnt / M, cnt % M)));
        if (vecs[vi].ec >= 0)
          chk({vecs[vi].name, "_hand"}, 32'(out_data), 32'(hand(vi, cnt / M, cnt % M)));
        if (vecs[vi].ident)
          chk({vecs[vi].name, "_pixel"}, 32'(out_data), 32'(px(vi, cnt)));
        cnt++;
      end else if (out_data != '0) begin
        zero_ok = 0;
      end
      in_valid = hold;
      in_img   = W1'($urandom);
      in_ker   = W2'($urandom);
    end
    chk({vecs[vi].name, "_frame_done"}, 32'(done), 1);
    chk({vecs[vi].name, "_zero_idle"}, 32'(zero_ok), 1);
    chk({vecs[vi].name, "_busy_high"}, 32'(busy_ok), 1);
  endtask

  initial begin
    bit quiet;
    vecs[0] = '{"ones",      0,  1,   0, 1'b0, 4,    6,     9,     1'b0};
    vecs[1] = '{"ident",     13, 0,   1, 1'b0, -1,   -1,    -1,    1'b1};
    vecs[2] = '{"max",       0,  255, 2, 1'b0, 7140, 10710, 16065, 1'b0};
    vecs[3] = '{"gaps",      37, 5,   3, 1'b1, -1,   -1,    -1,    1'b0};
    vecs[4] = '{"after_rst", 29, 11,  3, 1'b0, -1,   -1,    -1,    1'b0};

    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Each frame's beat 0 lands in the cycle right after the previous final result.
    for (int v = 0; v < 4; v++) begin
      send_frame(v);
      collect(v, vecs[v].gaps, 0);
    end

    // Reset during the 3rd tap of output (1,2), then a clean frame.
    send_frame(3);
    collect(3, 1'b0, 63);
    chk("busy_pre_rst", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_data", 32'(out_data), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) quiet = 0;
    end
    chk("quiet_after_rst", 32'(quiet), 1);
    send_frame(4);
    collect(4, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
